// File: rtl/perf_section_scheduler_if.sv
// Request/response handshake between the requesters and the section scheduler.
interface perf_section_scheduler_if #(
    parameter int unsigned NUM_REQ = 4
);
    localparam int unsigned ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req_valid;
    logic [2*NUM_REQ-1:0] req_cmd;
    logic [2*NUM_REQ-1:0] req_section;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 resp_valid;
    logic [ID_W-1:0]      resp_id;
    logic                 resp_err;
    logic [63:0]          resp_data;
    logic                 busy;

    // Requester side
    modport master (
        output req_valid, req_cmd, req_section,
        input  req_ready, resp_valid, resp_id, resp_err, resp_data, busy
    );

    // Scheduler side
    modport slave (
        input  req_valid, req_cmd, req_section,
        output req_ready, resp_valid, resp_id, resp_err, resp_data, busy
    );
endinterface

// File: rtl/perf_section_scheduler.sv
// Round-robin scheduler that turns section commands from several requesters into single
// Avalon-MM accesses on the performance-counter control slave. Snapshots read hi/lo/hi and
// re-read lo when the high word moved, so the 64-bit result is carry-safe.
module perf_section_scheduler #(
    parameter int unsigned          NUM_REQ   = 4,
    parameter logic [NUM_REQ-1:0]   GRST_MASK = NUM_REQ'(1)
) (
    input  logic                     clk,
    input  logic                     reset,
    perf_section_scheduler_if.slave  bus,
    output logic [3:0]               avm_address,
    output logic                     avm_write,
    output logic                     avm_begintransfer,
    output logic [31:0]              avm_writedata,
    output logic                     avm_read,
    input  logic [31:0]              avm_readdata
);
    localparam int unsigned ID_W = $clog2(NUM_REQ);

    localparam logic [1:0] CmdGo   = 2'b00;
    localparam logic [1:0] CmdStop = 2'b01;
    localparam logic [1:0] CmdGrst = 2'b10;
    localparam logic [1:0] CmdSnap = 2'b11;

    typedef enum logic [3:0] {
        StIdle,
        StWr,
        StRdHi1,
        StRdLo,
        StRdHi2,
        StRdChk,
        StRdLo2,
        StRdCap,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [1:0]        sec_q, sec_d;
    logic [3:0]        addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       hi1_q, hi1_d;
    logic [31:0]       lo_q, lo_d;
    logic [31:0]       hi2_q, hi2_d;
    logic [63:0]       resp_data_q, resp_data_d;
    logic              resp_err_q, resp_err_d;
    logic [ID_W-1:0]   resp_id_q, resp_id_d;

    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W-1:0]   cand;
    logic [1:0]        grant_cmd;
    logic [1:0]        grant_sec;

    // Round-robin pick: first valid requester at or after the pointer, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = ID_W'((32'(ptr_q) + i) % NUM_REQ);
            if (!grant_found && bus.req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
        grant_cmd = bus.req_cmd[{grant_idx, 1'b0} +: 2];
        grant_sec = bus.req_section[{grant_idx, 1'b0} +: 2];
    end

    // Next-state, datapath loads and Avalon/handshake strobes.
    always_comb begin
        state_d           = state_q;
        ptr_d             = ptr_q;
        id_d              = id_q;
        sec_d             = sec_q;
        addr_d            = addr_q;
        wdata_d           = wdata_q;
        hi1_d             = hi1_q;
        lo_d              = lo_q;
        hi2_d             = hi2_q;
        resp_data_d       = resp_data_q;
        resp_err_d        = resp_err_q;
        resp_id_d         = resp_id_q;
        bus.req_ready     = '0;
        bus.resp_valid    = 1'b0;
        avm_write         = 1'b0;
        avm_begintransfer = 1'b0;
        avm_writedata     = '0;
        avm_read          = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (grant_found && !reset) begin
                    bus.req_ready[grant_idx] = 1'b1;
                    id_d  = grant_idx;
                    sec_d = grant_sec;
                    ptr_d = (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
                    unique case (grant_cmd)
                        CmdGo: begin
                            addr_d  = {grant_sec, 2'b01};
                            wdata_d = 32'd0;
                            state_d = StWr;
                        end
                        CmdStop: begin
                            addr_d  = {grant_sec, 2'b00};
                            wdata_d = 32'd0;
                            state_d = StWr;
                        end
                        CmdGrst: begin
                            if (GRST_MASK[grant_idx]) begin
                                addr_d  = 4'd0;
                                wdata_d = 32'd1;
                                state_d = StWr;
                            end else begin
                                // Refused: complete straight away without touching the slave.
                                resp_id_d   = grant_idx;
                                resp_err_d  = 1'b1;
                                resp_data_d = 64'd0;
                                state_d     = StDone;
                            end
                        end
                        CmdSnap: begin
                            addr_d  = {grant_sec, 2'b01};
                            state_d = StRdHi1;
                        end
                        default: state_d = StIdle;
                    endcase
                end
            end
            StWr: begin
                avm_write         = 1'b1;
                avm_begintransfer = 1'b1;
                avm_writedata     = wdata_q;
                resp_id_d         = id_q;
                resp_err_d        = 1'b0;
                resp_data_d       = 64'd0;
                state_d           = StDone;
            end
            StRdHi1: begin
                avm_read = 1'b1;
                addr_d   = {sec_q, 2'b00};
                state_d  = StRdLo;
            end
            StRdLo: begin
                avm_read = 1'b1;
                hi1_d    = avm_readdata;
                addr_d   = {sec_q, 2'b01};
                state_d  = StRdHi2;
            end
            StRdHi2: begin
                avm_read = 1'b1;
                lo_d     = avm_readdata;
                state_d  = StRdChk;
            end
            StRdChk: begin
                resp_id_d  = id_q;
                resp_err_d = 1'b0;
                if (avm_readdata == hi1_q) begin
                    resp_data_d = {hi1_q, lo_q};
                    state_d     = StDone;
                end else begin
                    // High word moved during the read: lo may have wrapped, fetch it again.
                    hi2_d   = avm_readdata;
                    addr_d  = {sec_q, 2'b00};
                    state_d = StRdLo2;
                end
            end
            StRdLo2: begin
                avm_read = 1'b1;
                state_d  = StRdCap;
            end
            StRdCap: begin
                resp_data_d = {hi2_q, avm_readdata};
                state_d     = StDone;
            end
            StDone: begin
                bus.resp_valid = 1'b1;
                state_d        = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset abandons any in-flight command.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            id_q        <= '0;
            sec_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            hi1_q       <= '0;
            lo_q        <= '0;
            hi2_q       <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
            resp_id_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            sec_q       <= sec_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            hi1_q       <= hi1_d;
            lo_q        <= lo_d;
            hi2_q       <= hi2_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
            resp_id_q   <= resp_id_d;
        end
    end

    assign avm_address   = addr_q;
    assign bus.resp_id   = resp_id_q;
    assign bus.resp_err  = resp_err_q;
    assign bus.resp_data = resp_data_q;
    assign bus.busy      = (state_q != StIdle);

endmodule
